// File: rtl/servo_pwm_bank.sv
// Multi-channel frame-synchronous servo PWM generator.
// Target widths are clamped on write, and each channel's width slews toward its target once per frame.
module servo_pwm_bank #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned CLK_DIV   = 10,
  parameter int unsigned PERIOD    = 20000,
  parameter int unsigned MIN_PULSE = 1000,
  parameter int unsigned MAX_PULSE = 2000,
  parameter int unsigned CENTER    = 1500,
  parameter int unsigned SLEW      = 10
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [NUM_CH-1:0] ch_enable,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] at_target,
  output logic              frame_start
);

  localparam int unsigned PS_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PS_W-1:0]  PS_LAST    = PS_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] MAX_W      = CNT_W'(MAX_PULSE);
  localparam logic [CNT_W-1:0] CENTER_W   = CNT_W'(CENTER);
  localparam logic [CNT_W-1:0] SLEW_W     = CNT_W'(SLEW);

  localparam logic signed [CNT_W:0] SLEW_S = (CNT_W + 1)'(SLEW);

  logic [PS_W-1:0]               prescaler;
  logic [CNT_W-1:0]              frame_cnt;
  logic                          tick_c;
  logic                          boundary_c;
  logic [NUM_CH-1:0][CNT_W-1:0]  target;
  logic [NUM_CH-1:0][CNT_W-1:0]  cur;
  logic [NUM_CH-1:0][CNT_W-1:0]  next_cur_c;
  logic signed [CNT_W:0]         diff_c [NUM_CH];
  logic [NUM_CH-1:0]             act_en;
  logic [CNT_W-1:0]              wr_clamped_c;

  assign tick_c     = (prescaler == PS_LAST);
  assign boundary_c = tick_c && (frame_cnt == FRAME_LAST);

  // Clamp the requested width into the safe servo range.
  always_comb begin
    wr_clamped_c = wr_data;
    if (wr_data < MIN_W) begin
      wr_clamped_c = MIN_W;
    end else if (wr_data > MAX_W) begin
      wr_clamped_c = MAX_W;
    end
  end

  // Per-frame slew step; both operands lie in [MIN,MAX] so the signed difference cannot wrap.
  always_comb begin
    next_cur_c = target;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      diff_c[i] = $signed({1'b0, target[i]}) - $signed({1'b0, cur[i]});
      if (SLEW != 0) begin
        if (diff_c[i] > SLEW_S) begin
          next_cur_c[i] = cur[i] + SLEW_W;
        end else if (diff_c[i] < -SLEW_S) begin
          next_cur_c[i] = cur[i] - SLEW_W;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      prescaler   <= '0;
      frame_cnt   <= '0;
      target      <= {NUM_CH{CENTER_W}};
      cur         <= {NUM_CH{CENTER_W}};
      act_en      <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      prescaler <= tick_c ? '0 : prescaler + PS_W'(1);
      if (tick_c) begin
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + CNT_W'(1);
      end
      frame_start <= boundary_c;
      // Width and enable only change at the boundary, so the next frame is never a runt.
      if (boundary_c) begin
        cur    <= next_cur_c;
        act_en <= ch_enable;
      end
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (wr_en && (wr_ch == 4'(i))) begin
          target[i] <= wr_clamped_c;
        end
        pwm_out[i] <= act_en[i] && (frame_cnt < cur[i]);
      end
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      at_target[i] = (cur[i] == target[i]);
    end
  end

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Bench for servo_pwm_bank: a slewed instance and an immediate (SLEW=0) instance
// share all inputs, with a scaled-down frame so many frames fit in a short run.
module tb_servo_pwm_bank;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned PERIOD    = 40;
  localparam int unsigned MIN_PULSE = 10;
  localparam int unsigned MAX_PULSE = 30;
  localparam int unsigned CENTER    = 20;
  localparam int unsigned SLEW      = 3;
  localparam int          FRAME_CYC = int'(PERIOD * CLK_DIV);

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] pwm_a, pwm_b, at_a, at_b;
  logic              fs_a, fs_b;

  int checks;
  int failures;
  int wa [NUM_CH];
  int wb [NUM_CH];
  logic first_hi;

  servo_pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD),
    .MIN_PULSE(MIN_PULSE), .MAX_PULSE(MAX_PULSE), .CENTER(CENTER), .SLEW(SLEW)
  ) u_slew (
    .SYSCLK(clk), .SYSRESET(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .ch_enable(ch_enable), .pwm_out(pwm_a), .at_target(at_a), .frame_start(fs_a)
  );

  servo_pwm_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CLK_DIV(CLK_DIV), .PERIOD(PERIOD),
    .MIN_PULSE(MIN_PULSE), .MAX_PULSE(MAX_PULSE), .CENTER(CENTER), .SLEW(0)
  ) u_imm (
    .SYSCLK(clk), .SYSRESET(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .ch_enable(ch_enable), .pwm_out(pwm_b), .at_target(at_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic            wr;
    logic [3:0]      ch;
    logic [15:0]     data;
    logic [3:0]      en;
    logic [3:0][7:0] wa;
    logic [3:0][7:0] wb;
    logic [3:0]      ata;
    logic [3:0]      atb;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [3:0][7:0] w4(input int c0, input int c1, input int c2, input int c3);
    logic [3:0][7:0] r;
    r[0] = 8'(c0);
    r[1] = 8'(c1);
    r[2] = 8'(c2);
    r[3] = 8'(c3);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Runs one frame from a frame_start sample point to the next, counting high cycles per channel.
  task automatic run_frame(input int wr_k, input logic [3:0] ch, input logic [15:0] data,
                           input int en_k, input logic [3:0] en_v);
    for (int c = 0; c < int'(NUM_CH); c++) begin
      wa[c] = 0;
      wb[c] = 0;
    end
    first_hi = 1'b0;
    for (int k = 0; k <= FRAME_CYC; k++) begin
      if (k > 0) begin
        @(negedge clk);
        for (int c = 0; c < int'(NUM_CH); c++) begin
          wa[c] += int'(pwm_a[c]);
          wb[c] += int'(pwm_b[c]);
        end
        if (k == 1) begin
          first_hi = pwm_a[0];
          chk("frame_start_one_cycle", int'(fs_a), 0);
        end
      end
      if (wr_en) wr_en = 1'b0;
      if (k == wr_k) begin
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_data = data;
      end
      if (k == en_k) ch_enable = en_v;
    end
    chk("frame_sync", int'(fs_a), 1);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    while (!fs_a && n < 4 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    assert (MIN_PULSE <= CENTER && CENTER <= MAX_PULSE && MAX_PULSE < PERIOD && PERIOD < (1 << CNT_W))
      else $fatal(1, "illegal configuration");

    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_ch     = 4'd0;
    wr_data   = '0;
    ch_enable = 4'b0001;

    // Per-frame vectors: inputs applied at frame start, widths are of that same frame (cycles).
    tbl[0] = '{wr:1'b0, ch:4'd0, data:16'd0,  en:4'b1111, wa:w4(40, 0, 0, 0),   wb:w4(40, 0, 0, 0),   ata:4'b1111, atb:4'b1111};
    tbl[1] = '{wr:1'b1, ch:4'd1, data:16'd30, en:4'b1111, wa:w4(40, 40, 40, 40), wb:w4(40, 40, 40, 40), ata:4'b1101, atb:4'b1111};
    tbl[2] = '{wr:1'b1, ch:4'd3, data:16'd27, en:4'b1111, wa:w4(40, 46, 40, 40), wb:w4(40, 60, 40, 40), ata:4'b0101, atb:4'b1111};
    tbl[3] = '{wr:1'b1, ch:4'd2, data:16'd50, en:4'b1111, wa:w4(40, 52, 40, 46), wb:w4(40, 60, 40, 54), ata:4'b0001, atb:4'b1111};
    tbl[4] = '{wr:1'b1, ch:4'd2, data:16'd5,  en:4'b1111, wa:w4(40, 58, 46, 52), wb:w4(40, 60, 60, 54), ata:4'b1011, atb:4'b1111};
    tbl[5] = '{wr:1'b1, ch:4'd4, data:16'd30, en:4'b1111, wa:w4(40, 60, 40, 54), wb:w4(40, 60, 20, 54), ata:4'b1011, atb:4'b1111};
    tbl[6] = '{wr:1'b0, ch:4'd0, data:16'd0,  en:4'b1110, wa:w4(40, 60, 34, 54), wb:w4(40, 60, 20, 54), ata:4'b1011, atb:4'b1111};
    tbl[7] = '{wr:1'b0, ch:4'd0, data:16'd0,  en:4'b1111, wa:w4(0, 60, 28, 54),  wb:w4(0, 60, 20, 54),  ata:4'b1011, atb:4'b1111};
    tbl[8] = '{wr:1'b0, ch:4'd0, data:16'd0,  en:4'b1111, wa:w4(40, 60, 22, 54), wb:w4(40, 60, 20, 54), ata:4'b1111, atb:4'b1111};
    tbl[9] = '{wr:1'b0, ch:4'd0, data:16'd0,  en:4'b1111, wa:w4(40, 60, 20, 54), wb:w4(40, 60, 20, 54), ata:4'b1111, atb:4'b1111};

    repeat (3) @(negedge clk);
    chk("reset_pwm_a", int'(pwm_a), 0);
    chk("reset_pwm_b", int'(pwm_b), 0);
    chk("reset_at_target", int'(at_a), 15);
    chk("reset_frame_start", int'(fs_a), 0);
    rst = 1'b0;
    wait_fs(n);
    chk("first_frame_start_latency", n, FRAME_CYC);

    for (int s = 0; s < 10; s++) begin
      run_frame(tbl[s].wr ? 0 : -1, tbl[s].ch, tbl[s].data, 0, tbl[s].en);
      for (int c = 0; c < int'(NUM_CH); c++) begin
        chk($sformatf("vec%0d_width_slew_ch%0d", s, c), wa[c], int'(tbl[s].wa[c]));
        chk($sformatf("vec%0d_width_imm_ch%0d", s, c), wb[c], int'(tbl[s].wb[c]));
      end
      chk($sformatf("vec%0d_at_target_slew", s), int'(at_a), int'(tbl[s].ata));
      chk($sformatf("vec%0d_at_target_imm", s), int'(at_b), int'(tbl[s].atb));
    end

    // Enable deasserted mid-pulse, then reasserted mid-frame.
    run_frame(-1, 4'd0, 16'd0, 10, 4'b1110);
    chk("deassert_pulse_completes", wa[0], 40);
    run_frame(-1, 4'd0, 16'd0, 10, 4'b1111);
    chk("disabled_frame_low", wa[0], 0);
    chk("rise_not_at_frame_start", int'(pwm_a[0]), 0);
    run_frame(-1, 4'd0, 16'd0, -1, 4'b1111);
    chk("reenabled_width", wa[0], 40);
    chk("rise_one_cycle_after_frame_start", int'(first_hi), 1);

    // Write landing on the boundary edge: slew uses the old target.
    run_frame(FRAME_CYC - 1, 4'd3, 16'd12, -1, 4'b1111);
    chk("race_at_target_slew", int'(at_a), 4'b0111);
    chk("race_at_target_imm", int'(at_b), 4'b0111);
    run_frame(-1, 4'd0, 16'd0, -1, 4'b1111);
    chk("race_frame1_slew_ch3", wa[3], 54);
    chk("race_frame1_imm_ch3", wb[3], 54);
    run_frame(-1, 4'd0, 16'd0, -1, 4'b1111);
    chk("race_frame2_slew_ch3", wa[3], 48);
    chk("race_frame2_imm_ch3", wb[3], 24);

    // Reset in the middle of a pulse.
    repeat (5) @(negedge clk);
    chk("pre_reset_pulse_high", int'(pwm_a[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_pwm_a", int'(pwm_a), 0);
    chk("midreset_pwm_b", int'(pwm_b), 0);
    chk("midreset_at_target", int'(at_a), 15);
    chk("midreset_frame_start", int'(fs_a), 0);
    rst = 1'b0;
    wait_fs(n);
    chk("restart_frame_start_latency", n, FRAME_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_bank.md
Name: servo_pwm_bank

Overview:
- Parametrised multi-channel servo PWM generator for the fabric side of the MSS. It replaces single-pin GPO toggling of the continuous-rotation servos.
- Firmware writes a target pulse width per channel. The block produces frame-synchronous PWM on every channel.
- Pulse-width changes are slew-limited once per frame, so the Segway drive servos never see step changes.
- Widths are clamped to a safe range. Enables take effect only at frame boundaries, so no runt pulses are generated.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- CNT_W, 16, width of pulse and frame counters in ticks.
- CLK_DIV, 10, SYSCLK cycles per tick (10 MHz -> 1 us tick); must be >= 1.
- PERIOD, 20000, ticks per frame (20 ms).
- MIN_PULSE, 1000, lowest allowed pulse width in ticks.
- MAX_PULSE, 2000, highest allowed pulse width in ticks.
- CENTER, 1500, reset/neutral pulse width in ticks (stop for continuous servos).
- SLEW, 10, maximum width change per frame in ticks; 0 = apply target immediately.

Ports:
- SYSCLK  in  1  system clock.
- SYSRESET  in  1  synchronous reset, active high.
- wr_en  in  1  single-cycle write strobe for a target width.
- wr_ch  in  4  channel index for the write.
- wr_data  in  CNT_W  requested pulse width in ticks.
- ch_enable  in  NUM_CH  per-channel output enable (level).
- pwm_out  out  NUM_CH  registered PWM outputs.
- at_target  out  NUM_CH  1 when the channel's current width equals its target.
- frame_start  out  1  one-cycle pulse on each frame boundary.

Behaviour:
- Clock and reset: one clock (SYSCLK). SYSRESET is synchronous and active high. On the first edge with SYSRESET=1 the block enters reset state:
  - prescaler=0, frame_cnt=0;
  - target[i]=cur[i]=CENTER;
  - act_en[i]=0, pwm_out=0, frame_start=0, at_target=all 1.
- Reset mid-pulse: all outputs are low from the next edge. No partial pulse completes.
- Prescaler: counts 0..CLK_DIV-1. tick=1 in the cycle where prescaler==CLK_DIV-1, then the prescaler wraps to 0.
- Frame counter: advances on tick only, 0..PERIOD-1, wrapping to 0.
- Frame boundary: boundary = tick && frame_cnt==PERIOD-1. frame_start is registered and is high in the cycle after the boundary edge, for exactly 1 cycle.
- Write path:
  - On wr_en with wr_ch<NUM_CH, target[wr_ch] <= clamp(wr_data, MIN_PULSE, MAX_PULSE) at that edge.
  - wr_ch>=NUM_CH: the write is dropped and no state changes.
  - Back-to-back writes to the same channel: the last one wins.
- Slew update: at a boundary edge, for each channel with diff = target - cur:
  - SLEW==0 or |diff|<=SLEW: cur <= target;
  - diff>0: cur <= cur+SLEW;
  - diff<0: cur <= cur-SLEW.
  - Arithmetic is done in CNT_W+1 signed bits; no wrap is possible because both values are within [MIN,MAX].
- Write coincident with a boundary: the slew step uses the old target. The new target is first seen at the next boundary.
- Enable: act_en <= ch_enable at each boundary edge only. A mid-frame deassert completes the current pulse. A mid-frame assert waits for the next frame.
- Output: pwm_out[i] <= act_en[i] && (frame_cnt < cur[i]), registered. Pulse length is cur[i] ticks = cur[i]*CLK_DIV cycles. The rising edge lags the counter wrap by 1 cycle.
- at_target: at_target[i] = (cur[i]==target[i]), combinational from registers.
- Legal configuration: MIN_PULSE<=CENTER<=MAX_PULSE<PERIOD<2^CNT_W. The bench asserts this at elaboration.

Test Plan:
- Reset state: hold SYSRESET 3 cycles, release -> pwm_out=0000, at_target=1111, first frame_start 200000 cycles after release.
- Neutral pulse: ch_enable=0001 before boundary, defaults -> pwm_out[0] high 15000 cycles each 200000-cycle frame; others low.
- Slew ramp: write ch1=2000 with SLEW=10, ch1 enabled -> successive pulse widths 1510, 1520, ... ticks; width reaches 2000 at the 50th boundary after the write; at_target[1] rises then.
- Clamp and invalid channel:
  - write ch2=2500 -> target 2000;
  - write ch2=500 -> target 1000;
  - wr_ch=4 (NUM_CH=4) -> no target changes, at_target unchanged.
- Enable gating: deassert ch_enable[0] 5000 cycles into a pulse -> the current 15000-cycle pulse completes; the next frame stays low. Reasserting mid-frame -> output resumes only after the next frame_start.
- Immediate mode and boundary race:
  - SLEW=0: write ch3=1800 -> the next frame's pulse is 18000 cycles.
  - Write coincident with a boundary edge -> the change appears one frame later.
  - SYSRESET mid-pulse -> pwm_out=0 on the next cycle.
